// File: rtl/spi_serf_pkg.sv
// spi_serf shared definitions: FSM state type and default geometry.
// Used by spi_serf, spi_serf_if and spi_sync_edge.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} serf_state_t;

  localparam int SPI_WIDTH = 16;
  localparam int SYNC_DEF  = 2;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_serf_if.sv
// Host-side handshake of the SPI serf: transmit load, received frame and
// ready/acknowledge. master = host logic, slave = spi_serf.
// Optional: SPI_SERF_FRM_ERR_EN adds the frm_err status signal.
interface spi_serf_if #(
  parameter int WIDTH = spi_pkg::SPI_WIDTH
) ();

  logic             wrt;
  logic [WIDTH-1:0] tx_data;
  logic             clr_rdy;
  logic [WIDTH-1:0] rx_data;
  logic             rdy;
`ifdef SPI_SERF_FRM_ERR_EN
  logic             frm_err;

  modport master (output wrt, tx_data, clr_rdy, input rx_data, rdy, frm_err);
  modport slave  (input wrt, tx_data, clr_rdy, output rx_data, rdy, frm_err);
`else
  modport master (output wrt, tx_data, clr_rdy, input rx_data, rdy);
  modport slave  (input wrt, tx_data, clr_rdy, output rx_data, rdy);
`endif

endinterface

// File: rtl/spi_serf_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one asynchronous SPI pin plus
// an edge flop for rise/fall detection in the clk domain.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = spi_pkg::SYNC_DEF,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;

  // Shift the pin through the metastability chain, then keep one more copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_edge <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_edge;
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_edge;

endmodule

// File: rtl/spi_serf.sv
// spi_serf: 16-bit SPI responder, SCLK idles high, MSB first. All SPI pins
// are synchronized into clk; nothing is clocked by SCLK.
// Optional: define SPI_SERF_FRM_ERR_EN to add frm_err and overflow tracking.
module spi_serf
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       SCLK,
  input  logic       MOSI,
  output wire        MISO,
  spi_serf_if.slave  host
);

  localparam int                CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WIDTH);
  localparam int                WARM_W    = cnt_width(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

  logic w_ss_sync, w_ss_rise, w_ss_fall;
  logic w_sclk_sync, w_sclk_rise, w_unused_sclk_fall;
  logic w_mosi_sync, w_unused_mosi_rise, w_unused_mosi_fall;

  serf_state_t       r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WIDTH-1:0]  r_shft_reg;
  logic [WIDTH-1:0]  r_rx_data;
  logic              r_rdy;
  logic [WARM_W-1:0] r_warm;
  logic              r_armed;
  logic              w_unused_sclk_sync;
`ifdef SPI_SERF_FRM_ERR_EN
  logic              r_ovf;
  logic              r_frm_err;
`endif

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SS_n),
    .o_sync (w_ss_sync),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SCLK),
    .o_sync (w_sclk_sync),
    .o_rise (w_sclk_rise),
    .o_fall (w_unused_sclk_fall)
  );

  // MOSI goes through the same depth as SCLK so the sample lines up with SCLK_rise.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(MOSI),
    .o_sync (w_mosi_sync),
    .o_rise (w_unused_mosi_rise),
    .o_fall (w_unused_mosi_fall)
  );

  assign w_unused_sclk_sync = w_sclk_sync;

  // The SS_n chain resets high, so a pin held low through reset would look like
  // a fresh fall; only accept SS_fall once the chain has flushed and SS_n was seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm  <= '0;
      r_armed <= 1'b0;
    end else begin
      if (r_warm != WARM_DONE) r_warm <= r_warm + 1'b1;
      if (r_warm == WARM_DONE && w_ss_sync) r_armed <= 1'b1;
    end
  end

  // Frame FSM: IDLE accepts tx loads, ACTIVE shifts on SCLK rises and captures on SS_rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shft_reg <= '0;
      r_rx_data  <= '0;
      r_rdy      <= 1'b0;
`ifdef SPI_SERF_FRM_ERR_EN
      r_ovf      <= 1'b0;
      r_frm_err  <= 1'b0;
`endif
    end else begin
      // Acknowledge first so that a same-cycle capture below wins.
      if (host.clr_rdy) begin
        r_rdy <= 1'b0;
`ifdef SPI_SERF_FRM_ERR_EN
        r_frm_err <= 1'b0;
`endif
      end
      case (r_state)
        IDLE: begin
          if (host.wrt) r_shft_reg <= host.tx_data;
          if (w_ss_fall && r_armed) begin
            r_state   <= ACTIVE;
            r_bit_cnt <= '0;
            r_rdy     <= 1'b0;
`ifdef SPI_SERF_FRM_ERR_EN
            r_ovf     <= 1'b0;
            r_frm_err <= 1'b0;
`endif
          end
        end
        ACTIVE: begin
          if (w_ss_rise) begin
            r_state <= IDLE;
`ifdef SPI_SERF_FRM_ERR_EN
            if (r_bit_cnt == CNT_FULL && !r_ovf) begin
              r_rx_data <= r_shft_reg;
              r_rdy     <= 1'b1;
            end
            r_frm_err <= (r_bit_cnt != CNT_FULL) || r_ovf;
`else
            if (r_bit_cnt == CNT_FULL) begin
              r_rx_data <= r_shft_reg;
              r_rdy     <= 1'b1;
            end
`endif
          end else if (w_sclk_rise) begin
            r_shft_reg <= {r_shft_reg[WIDTH-2:0], w_mosi_sync};
            if (r_bit_cnt != CNT_FULL) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
`ifdef SPI_SERF_FRM_ERR_EN
            else begin
              r_ovf <= 1'b1;
            end
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MISO         = w_ss_sync ? 1'bz : r_shft_reg[WIDTH-1];
  assign host.rx_data = r_rx_data;
  assign host.rdy     = r_rdy;
`ifdef SPI_SERF_FRM_ERR_EN
  assign host.frm_err = r_frm_err;
`endif

endmodule

// File: tb/tb_spi_serf.sv
// Scoreboard bench for spi_serf: a monarch bus-functional model drives frames,
// expected received frames are queued, and a monitor checks each rdy rise.
// Honours SPI_SERF_FRM_ERR_EN when defined.
module tb_spi_serf;
  import spi_pkg::*;

  localparam int W = SPI_WIDTH;
  localparam int H = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n  = 1'b1;
  logic SCLK  = 1'b1;
  logic MOSI  = 1'b0;
  wire  miso_w;

  spi_serf_if #(.WIDTH(W)) host_if ();

  spi_serf #(.WIDTH(W), .SYNC_STAGES(SYNC_DEF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (miso_w),
    .host (host_if)
  );

  always #5 clk = ~clk;

  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int ss_rise_cyc = 0;
  logic [15:0] exp_q[$];
  logic        prev_rdy = 1'b0;
  logic [15:0] model_s  = '0;
  logic [15:0] model_rx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every new rdy must match the oldest queued frame and arrive 3 clk after SS_n rose.
  always @(negedge clk) begin
    if (rst_n && host_if.rdy && !prev_rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rdy", 32'(host_if.rx_data), 32'hDEAD_0000);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("rx_data", 32'(host_if.rx_data), 32'(e));
        chk("rdy_latency", 32'(cyc - ss_rise_cyc), 32'd3);
      end
    end
    prev_rdy = host_if.rdy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic host_wrt(input logic [15:0] v);
    @(negedge clk);
    host_if.tx_data = v;
    host_if.wrt     = 1'b1;
    @(negedge clk);
    host_if.wrt     = 1'b0;
  endtask

  // Monarch BFM: MOSI changes after SCLK falls, MISO sampled just before SCLK rises.
  task automatic spi_frame(input int n, input logic [31:0] d, output logic [31:0] r,
                           input int rst_bit, input int wrt_bit, input bit clr_at_done);
    r = '0;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      SCLK = 1'b0;
      MOSI = d[n-1-k];
      if (k == rst_bit) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (k == wrt_bit) begin
        host_if.tx_data = 16'hFFFF;
        host_if.wrt     = 1'b1;
        @(negedge clk);
        host_if.wrt     = 1'b0;
      end
      repeat (H) @(negedge clk);
      r = {r[30:0], miso_w};
      SCLK = 1'b1;
      repeat (H) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    SS_n        = 1'b1;
    ss_rise_cyc = cyc;
    repeat (2) @(negedge clk);
    if (clr_at_done) host_if.clr_rdy = 1'b1;
    @(negedge clk);
    host_if.clr_rdy = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] rnd;
    logic [15:0] d;
    logic [19:0] dl;
    host_if.wrt     = 1'b0;
    host_if.tx_data = '0;
    host_if.clr_rdy = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_rdy", 32'(host_if.rdy), 32'd0);
    chk("reset_rx", 32'(host_if.rx_data), 32'd0);
`ifdef SPI_SERF_FRM_ERR_EN
    chk("reset_frm_err", 32'(host_if.frm_err), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Loaded response, monarch sends 1234.
    host_wrt(16'hA5C3);
    model_s = 16'hA5C3;
    exp_q.push_back(16'h1234);
    spi_frame(16, 32'h1234, r, -1, -1, 1'b0);
    chk("t1_miso", 32'(r[15:0]), 32'hA5C3);
    model_s = 16'h1234; model_rx = 16'h1234;
    chk("t1_rdy", 32'(host_if.rdy), 32'd1);

    // No load: previous frame echoed.
    exp_q.push_back(16'hBEEF);
    spi_frame(16, 32'hBEEF, r, -1, -1, 1'b0);
    chk("t2_echo", 32'(r[15:0]), 32'(model_s));
    model_s = 16'hBEEF; model_rx = 16'hBEEF;

    // Short frame of 10 bits is discarded.
    rnd = $urandom();
    spi_frame(10, {22'd0, rnd[9:0]}, r, -1, -1, 1'b0);
    chk("t3_short_miso", 32'(r[9:0]), 32'(model_s[15:6]));
    model_s = {model_s[5:0], rnd[9:0]};
    chk("t3_short_rdy", 32'(host_if.rdy), 32'd0);
    chk("t3_short_rx", 32'(host_if.rx_data), 32'(model_rx));
`ifdef SPI_SERF_FRM_ERR_EN
    chk("t3_frm_err", 32'(host_if.frm_err), 32'd1);
`endif

    // clr_rdy on the completion clock loses to the set; a later clr_rdy clears.
    rnd = $urandom(); d = rnd[15:0];
    exp_q.push_back(d);
    spi_frame(16, 32'(d), r, -1, -1, 1'b1);
    chk("t4_miso", 32'(r[15:0]), 32'(model_s));
    model_s = d; model_rx = d;
    chk("t4_rdy_kept", 32'(host_if.rdy), 32'd1);
    @(negedge clk); host_if.clr_rdy = 1'b1;
    @(negedge clk); host_if.clr_rdy = 1'b0;
    chk("t4_rdy_cleared", 32'(host_if.rdy), 32'd0);

    // Reset at bit 7 aborts the frame; the next full frame works.
    rnd = $urandom();
    spi_frame(16, 32'(rnd[15:0]), r, 7, -1, 1'b0);
    model_s = '0; model_rx = '0;
    chk("t5_rst_rdy", 32'(host_if.rdy), 32'd0);
    chk("t5_rst_rx", 32'(host_if.rx_data), 32'd0);
    exp_q.push_back(16'h0F0F);
    spi_frame(16, 32'h0F0F, r, -1, -1, 1'b0);
    chk("t5_after_miso", 32'(r[15:0]), 32'(model_s));
    model_s = 16'h0F0F; model_rx = 16'h0F0F;

    // Load during an active frame is ignored.
    rnd = $urandom(); d = rnd[15:0];
    exp_q.push_back(d);
    spi_frame(16, 32'(d), r, -1, 5, 1'b0);
    chk("t6_wrt_ignored", 32'(r[15:0]), 32'(model_s));
    model_s = d; model_rx = d;
    rnd = $urandom(); d = rnd[15:0];
    exp_q.push_back(d);
    spi_frame(16, 32'(d), r, -1, -1, 1'b0);
    chk("t6_no_ffff", 32'(r[15:0]), 32'(model_s));
    model_s = d; model_rx = d;

    // 20-bit frame: shifting continues past WIDTH.
    rnd = $urandom(); dl = rnd[19:0];
`ifndef SPI_SERF_FRM_ERR_EN
    exp_q.push_back(dl[15:0]);
`endif
    spi_frame(20, 32'(dl), r, -1, -1, 1'b0);
    chk("t7_long_miso", 32'(r[19:0]), 32'({model_s, dl[19:16]}));
    model_s = dl[15:0];
`ifdef SPI_SERF_FRM_ERR_EN
    chk("t7_ovf_rdy", 32'(host_if.rdy), 32'd0);
    chk("t7_ovf_err", 32'(host_if.frm_err), 32'd1);
`else
    model_rx = dl[15:0];
`endif
    chk("t7_long_rx", 32'(host_if.rx_data), 32'(model_rx));

    // Random frames, optionally preceded by a load.
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        rnd = $urandom();
        host_wrt(rnd[15:0]);
        model_s = rnd[15:0];
      end
      rnd = $urandom(); d = rnd[15:0];
      exp_q.push_back(d);
      spi_frame(16, 32'(d), r, -1, -1, 1'b0);
      chk("rand_miso", 32'(r[15:0]), 32'(model_s));
      model_s = d; model_rx = d;
    end

    repeat (10) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
